// File: rtl/pi_midstate_frame_receiver.sv
// Frame receiver for the Raspberry Pi link: SYNC, 44 payload bytes, XOR checksum.
// Latches a checksum-valid frame into midstate/block_2_tail and holds a received flag until acked.
module pi_midstate_frame_receiver #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         PAYLOAD_BYTES  = 44,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         midstate_consumed,
    output logic [255:0] midstate,
    output logic [95:0]  block_2_tail,
    output logic         recieved_midstate_and_block_2,
    output logic         frame_error,
    output logic [7:0]   error_count
);

    localparam int SW = 8 * PAYLOAD_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        state;
    logic [5:0]    idx;
    logic [7:0]    xor_acc;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] shadow;

    logic timeout_hit;
    logic bad_sum;
    logic good_sum;
    logic err_evt;

    // Timeout fires on the idle cycle that would bring the gap count to TIMEOUT_CYCLES.
    always_comb begin
        timeout_hit = 1'b0;
        bad_sum     = 1'b0;
        good_sum    = 1'b0;
        if (state != IDLE && !rx_valid && tcnt == TW'(TIMEOUT_CYCLES - 1))
            timeout_hit = 1'b1;
        if (state == CHECK && rx_valid) begin
            if (rx_byte == xor_acc)
                good_sum = 1'b1;
            else
                bad_sum = 1'b1;
        end
        err_evt = timeout_hit | bad_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                         <= IDLE;
            idx                           <= '0;
            xor_acc                       <= '0;
            tcnt                          <= '0;
            shadow                        <= '0;
            midstate                      <= '0;
            block_2_tail                  <= '0;
            recieved_midstate_and_block_2 <= 1'b0;
            frame_error                   <= 1'b0;
            error_count                   <= '0;
        end else begin
            frame_error <= err_evt;
            if (err_evt && error_count != 8'hFF)
                error_count <= error_count + 8'd1;

            // A good frame latching in the same cycle as an ack keeps the flag set.
            if (good_sum) begin
                midstate                      <= shadow[SW-1 -: 256];
                block_2_tail                  <= shadow[95:0];
                recieved_midstate_and_block_2 <= 1'b1;
            end else if (midstate_consumed) begin
                recieved_midstate_and_block_2 <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (rx_valid && rx_byte == SYNC_BYTE) begin
                        state   <= PAYLOAD;
                        idx     <= '0;
                        xor_acc <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        tcnt    <= '0;
                        shadow  <= {shadow[SW-9:0], rx_byte};
                        xor_acc <= xor_acc ^ rx_byte;
                        idx     <= idx + 6'd1;
                        if (idx == 6'(PAYLOAD_BYTES - 1))
                            state <= CHECK;
                    end else if (timeout_hit) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    tcnt  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pi_midstate_frame_receiver.sv
// Directed and randomized bench for pi_midstate_frame_receiver with a byte-level frame model.
module tb_pi_midstate_frame_receiver;

    localparam int TO = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         midstate_consumed;
    logic [255:0] midstate;
    logic [95:0]  block_2_tail;
    logic         recieved_midstate_and_block_2;
    logic         frame_error;
    logic [7:0]   error_count;

    pi_midstate_frame_receiver #(
        .SYNC_BYTE      (SYNC),
        .PAYLOAD_BYTES  (44),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .rx_valid                      (rx_valid),
        .rx_byte                       (rx_byte),
        .midstate_consumed             (midstate_consumed),
        .midstate                      (midstate),
        .block_2_tail                  (block_2_tail),
        .recieved_midstate_and_block_2 (recieved_midstate_and_block_2),
        .frame_error                   (frame_error),
        .error_count                   (error_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: accepted frames queue, last latched frame, flag, error tally.
    logic [351:0] exp_q[$];
    logic [351:0] exp_cur;
    bit           exp_rcv;
    int           exp_errs;
    logic [7:0]   pl[44];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
    endtask

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pl_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 44; i++) x = x ^ pl[i];
        return x;
    endfunction

    // Payload byte i lands at bit position 351-8*i (first byte most significant).
    function automatic logic [351:0] pack();
        logic [351:0] v = '0;
        for (int i = 0; i < 44; i++) v[351 - 8*i -: 8] = pl[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_cnt();
        return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
    endfunction

    task automatic check_outputs(input string tag, input bit exp_err);
        chk({tag, "_midstate"}, midstate, exp_cur[351:96]);
        chk({tag, "_tail"}, block_2_tail, exp_cur[95:0]);
        chk({tag, "_recieved"}, recieved_midstate_and_block_2, exp_rcv);
        chk({tag, "_frame_error"}, frame_error, exp_err);
        chk({tag, "_error_count"}, error_count, exp_cnt());
    endtask

    task automatic run_frame(input string tag, input bit corrupt, input bit consume_last,
                             input int max_gap);
        logic [7:0] c;
        c = pl_xor();
        if (corrupt) c = c ^ 8'(8'h01 << $urandom_range(0, 7));
        send_byte(SYNC);
        gap(max_gap);
        for (int i = 0; i < 44; i++) begin
            send_byte(pl[i]);
            gap(max_gap);
        end
        midstate_consumed = consume_last;
        send_byte(c);
        midstate_consumed = 1'b0;
        if (!corrupt) begin
            exp_q.push_back(pack());
            exp_rcv = 1'b1;
        end else begin
            exp_errs++;
            if (consume_last) exp_rcv = 1'b0;
        end
        if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
        check_outputs(tag, corrupt);
        tick();
        chk({tag, "_pulse_end"}, frame_error, 1'b0);
    endtask

    task automatic fill_random(input bit with_sync);
        for (int i = 0; i < 44; i++) pl[i] = 8'($urandom_range(0, 255));
        if (with_sync) begin
            pl[0] = SYNC;
            pl[$urandom_range(1, 43)] = SYNC;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        midstate_consumed = 1'b0;
        exp_cur = '0;
        exp_rcv = 1'b0;
        exp_errs = 0;
        tick();
        tick();
        check_outputs("reset", 1'b0);
        rst = 1'b0;
        tick();

        // Incrementing payload 00..2B, back-to-back bytes.
        for (int i = 0; i < 44; i++) pl[i] = 8'(i);
        run_frame("t1_good", 1'b0, 1'b0, 0);
        chk("t1_mid_top", midstate[255:224], 32'h00010203);
        chk("t1_mid_low", midstate[31:0], 32'h1C1D1E1F);
        chk("t1_tail_top", block_2_tail[95:64], 32'h20212223);
        chk("t1_tail_low", block_2_tail[31:0], 32'h28292A2B);

        // Ack, then a bad checksum: outputs held, flag stays low.
        midstate_consumed = 1'b1;
        tick();
        midstate_consumed = 1'b0;
        exp_rcv = 1'b0;
        chk("t4_consume_clears", recieved_midstate_and_block_2, 1'b0);
        run_frame("t2_bad", 1'b1, 1'b0, 0);

        // Timeout after 10 payload bytes.
        send_byte(SYNC);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
        n = 0;
        while (n < 3 * TO) begin
            tick();
            n++;
            if (frame_error === 1'b1) break;
        end
        exp_errs++;
        chk("t3_timeout_cycles", n, TO);
        chk("t3_error_count", error_count, exp_cnt());
        chk("t3_midstate_held", midstate, exp_cur[351:96]);
        tick();
        chk("t3_pulse_end", frame_error, 1'b0);
        fill_random(1'b0);
        run_frame("t3_after", 1'b0, 1'b0, 0);

        // Consume with flag low has no effect; consume on latch cycle loses to set.
        midstate_consumed = 1'b1;
        tick();
        midstate_consumed = 1'b0;
        exp_rcv = 1'b0;
        midstate_consumed = 1'b1;
        tick();
        midstate_consumed = 1'b0;
        chk("t4_consume_idle", recieved_midstate_and_block_2, 1'b0);
        fill_random(1'b0);
        run_frame("t4_set_wins", 1'b0, 1'b1, 0);

        // Noise in IDLE, then a frame with SYNC values as data, overwriting a held frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        chk("t5_noise_no_err", frame_error, 1'b0);
        fill_random(1'b1);
        run_frame("t5_sync_data", 1'b0, 1'b0, 0);

        // Randomized frames: gaps, corruption, acks.
        for (int k = 0; k < 20; k++) begin
            fill_random($urandom_range(0, 1) == 1);
            run_frame("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 3);
        end

        // Reset mid-frame.
        send_byte(SYNC);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cur = '0;
        exp_rcv = 1'b0;
        exp_errs = 0;
        exp_q.delete();
        check_outputs("t6_reset", 1'b0);
        tick();
        chk("t6_no_err_after", frame_error, 1'b0);
        fill_random(1'b0);
        run_frame("t6_after", 1'b0, 1'b0, 0);

        // Saturation of error_count.
        for (int k = 0; k < 300; k++) run_frame("t6_sat", 1'b1, 1'b0, 0);
        chk("t6_saturated", error_count, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
